dma_address_counter: RTL and testbench

//  Per-channel address / word-count generator for the DMA (8237-style), 4 channels.

---
 rtl/dma_address_counter.sv | 217 +++++++++++++++++++++
 tb/tb_dma_address_counter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_address_counter.sv
// dma_address_counter: 8237-style per-channel address / word-count generator.
// The processor programs base/current address and count registers through a 16-entry I/O
// window while the bus is not granted. Once the bus is granted, the FSM presents the granted
// channel's current address, pulses address_ready, steps address/count on xfer_done and pulses
// TC when the count expires.
// Optional feature: define DMA_AUTOINIT_EN so that, at terminal count, a channel whose mode
// autoinit bit is set reloads its current registers from base and stays unmasked.
// Address/count registers are written a byte at a time, which assumes AW = 16.
module dma_address_counter #(
    parameter int unsigned NCH = 4,
    parameter int unsigned AW  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          IOW,
    input  logic [15:0]   address_bus,
    input  logic [7:0]    data_bus,
    input  logic          HLDA,
    input  logic [1:0]    chan_sel,
    input  logic          xfer_done,
    output logic [AW-1:0] address_out,
    output logic          address_ready,
    output logic          TC,
    output logic          busy
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAddr   = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;
    localparam logic [1:0] StUpdate = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [1:0]     ch_q, ch_d;
    logic [AW-1:0]  base_addr_q [NCH];
    logic [AW-1:0]  base_addr_d [NCH];
    logic [AW-1:0]  cur_addr_q  [NCH];
    logic [AW-1:0]  cur_addr_d  [NCH];
    logic [AW-1:0]  base_cnt_q  [NCH];
    logic [AW-1:0]  base_cnt_d  [NCH];
    logic [AW-1:0]  cur_cnt_q   [NCH];
    logic [AW-1:0]  cur_cnt_d   [NCH];
    logic [NCH-1:0] mask_q, mask_d;
    logic [NCH-1:0] mode_auto_q, mode_auto_d;
    logic [NCH-1:0] mode_dec_q, mode_dec_d;
    logic           bp_q, bp_d;
    logic           iow_q;

    logic [3:0]     reg_sel;
    logic [1:0]     wr_ch;
    logic           wr_en;
    logic           mclr;
    logic           cnt_zero;

    assign reg_sel  = address_bus[3:0];
    assign wr_ch    = reg_sel[2:1];
    // Writes only on the IOW falling edge, with the bus not granted and inside the 0..15 window.
    assign wr_en    = !cs && !IOW && iow_q && !HLDA && (address_bus[15:4] == 12'h000);
    assign mclr     = wr_en && (reg_sel == 4'd13);
    assign cnt_zero = (cur_cnt_q[ch_q] == '0);

`ifndef DMA_AUTOINIT_EN
    // Mode autoinit bit is kept for software read-compatibility but has no effect here.
    logic unused_autoinit;
    assign unused_autoinit = ^mode_auto_q;
`endif

    // Transfer sequencing: channel is latched on leaving IDLE and held until return to IDLE.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        unique case (state_q)
            StIdle: begin
                if (HLDA && !mask_q[chan_sel]) begin
                    state_d = StAddr;
                    ch_d    = chan_sel;
                end
            end
            StAddr: state_d = StWait;
            StWait: begin
                if (xfer_done) begin
                    state_d = StUpdate;
                end else if (!HLDA) begin
                    state_d = StIdle;
                end
            end
            StUpdate: begin
                if (cnt_zero || !HLDA) begin
                    state_d = StIdle;
                end else begin
                    state_d = StAddr;
                end
            end
            default: state_d = StIdle;
        endcase
        if (mclr) begin
            state_d = StIdle;
            ch_d    = '0;
        end
    end

    // Register file next state: transfer stepping first, then processor writes, then master clear.
    always_comb begin
        base_addr_d = base_addr_q;
        cur_addr_d  = cur_addr_q;
        base_cnt_d  = base_cnt_q;
        cur_cnt_d   = cur_cnt_q;
        mask_d      = mask_q;
        mode_auto_d = mode_auto_q;
        mode_dec_d  = mode_dec_q;
        bp_d        = bp_q;

        if (state_q == StUpdate) begin
            if (mode_dec_q[ch_q]) begin
                cur_addr_d[ch_q] = cur_addr_q[ch_q] - AW'(1);
            end else begin
                cur_addr_d[ch_q] = cur_addr_q[ch_q] + AW'(1);
            end
            cur_cnt_d[ch_q] = cur_cnt_q[ch_q] - AW'(1);
            if (cnt_zero) begin
`ifdef DMA_AUTOINIT_EN
                if (mode_auto_q[ch_q]) begin
                    cur_addr_d[ch_q] = base_addr_q[ch_q];
                    cur_cnt_d[ch_q]  = base_cnt_q[ch_q];
                end else begin
                    mask_d[ch_q] = 1'b1;
                end
`else
                mask_d[ch_q] = 1'b1;
`endif
            end
        end

        if (wr_en) begin
            if (!reg_sel[3]) begin
                // Channel address/count: BP selects low (0) or high (1) byte.
                if (reg_sel[0]) begin
                    if (bp_q) begin
                        base_cnt_d[wr_ch][15:8] = data_bus;
                        cur_cnt_d[wr_ch][15:8]  = data_bus;
                        mask_d[wr_ch]           = 1'b0;
                    end else begin
                        base_cnt_d[wr_ch][7:0] = data_bus;
                        cur_cnt_d[wr_ch][7:0]  = data_bus;
                    end
                end else begin
                    if (bp_q) begin
                        base_addr_d[wr_ch][15:8] = data_bus;
                        cur_addr_d[wr_ch][15:8]  = data_bus;
                    end else begin
                        base_addr_d[wr_ch][7:0] = data_bus;
                        cur_addr_d[wr_ch][7:0]  = data_bus;
                    end
                end
                bp_d = !bp_q;
            end else if (reg_sel == 4'd11) begin
                mode_auto_d[data_bus[1:0]] = data_bus[4];
                mode_dec_d[data_bus[1:0]]  = data_bus[5];
            end else if (reg_sel == 4'd12) begin
                bp_d = 1'b0;
            end
        end

        if (mclr) begin
            for (int i = 0; i < NCH; i++) begin
                base_addr_d[i] = '0;
                cur_addr_d[i]  = '0;
                base_cnt_d[i]  = '0;
                cur_cnt_d[i]   = '0;
            end
            mask_d      = '1;
            mode_auto_d = '0;
            mode_dec_d  = '0;
            bp_d        = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ch_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                base_addr_q[i] <= '0;
                cur_addr_q[i]  <= '0;
                base_cnt_q[i]  <= '0;
                cur_cnt_q[i]   <= '0;
            end
            mask_q      <= '1;
            mode_auto_q <= '0;
            mode_dec_q  <= '0;
            bp_q        <= 1'b0;
            iow_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            base_addr_q <= base_addr_d;
            cur_addr_q  <= cur_addr_d;
            base_cnt_q  <= base_cnt_d;
            cur_cnt_q   <= cur_cnt_d;
            mask_q      <= mask_d;
            mode_auto_q <= mode_auto_d;
            mode_dec_q  <= mode_dec_d;
            bp_q        <= bp_d;
            iow_q       <= IOW;
        end
    end

    // Outputs decode directly from state so reset forces them low immediately.
    always_comb begin
        busy          = (state_q != StIdle);
        address_out   = busy ? cur_addr_q[ch_q] : '0;
        address_ready = (state_q == StAddr);
        TC            = (state_q == StUpdate) && cnt_zero;
    end

endmodule

// File: tb/tb_dma_address_counter.sv
// Directed bench for dma_address_counter: a vector table for programming and a full ch1 run,
// followed by hand-written sequences for reset, decrement/wrap, write gating, HLDA drop,
// autoinit and master clear.
module tb_dma_address_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        IOW;
    logic [15:0] address_bus;
    logic [7:0]  data_bus;
    logic        HLDA;
    logic [1:0]  chan_sel;
    logic        xfer_done;
    logic [15:0] address_out;
    logic        address_ready;
    logic        TC;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        cs;
        logic        iow;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        hlda;
        logic [1:0]  chan;
        logic        xfer;
        logic [15:0] e_addr;
        logic        e_rdy;
        logic        e_tc;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    dma_address_counter dut (
        .clk          (clk),
        .reset        (reset),
        .cs           (cs),
        .IOW          (IOW),
        .address_bus  (address_bus),
        .data_bus     (data_bus),
        .HLDA         (HLDA),
        .chan_sel     (chan_sel),
        .xfer_done    (xfer_done),
        .address_out  (address_out),
        .address_ready(address_ready),
        .TC           (TC),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic expect_out(input string name, input logic [15:0] ea, input logic er,
                              input logic et, input logic eb);
        checks++;
        if ({address_out, address_ready, TC, busy} !== {ea, er, et, eb}) begin
            errors++;
            $display("FAIL %s: got addr=%h rdy=%b tc=%b busy=%b, want addr=%h rdy=%b tc=%b busy=%b",
                     name, address_out, address_ready, TC, busy, ea, er, et, eb);
        end
    endtask

    // Apply inputs on the falling edge; return just after the rising edge that consumed them.
    task automatic drive(input logic c, input logic i, input logic [15:0] a, input logic [7:0] d,
                         input logic h, input logic [1:0] ch, input logic x);
        @(negedge clk);
        cs          = c;
        IOW         = i;
        address_bus = a;
        data_bus    = d;
        HLDA        = h;
        chan_sel    = ch;
        xfer_done   = x;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic h, input logic [1:0] ch, input logic x);
        drive(1'b1, 1'b1, 16'h0000, 8'h00, h, ch, x);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        drive(1'b0, 1'b0, a, d, 1'b0, 2'd0, 1'b0);
        drive(1'b1, 1'b1, a, d, 1'b0, 2'd0, 1'b0);
    endtask

    function automatic void add(input logic c, input logic i, input logic [15:0] a,
                                input logic [7:0] d, input logic h, input logic [1:0] ch,
                                input logic x, input logic [15:0] ea, input logic er,
                                input logic et, input logic eb);
        vec_t v;
        v.cs = c; v.iow = i; v.addr = a; v.data = d; v.hlda = h; v.chan = ch; v.xfer = x;
        v.e_addr = ea; v.e_rdy = er; v.e_tc = et; v.e_busy = eb;
        vecs.push_back(v);
    endfunction

    // One processor write (strobe low then high) expecting the FSM to stay idle.
    function automatic void add_wr(input logic c, input logic [15:0] a, input logic [7:0] d);
        add(c, 1'b0, a, d, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, a, d, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic void add_run(input logic h, input logic [1:0] ch, input logic x,
                                    input logic [15:0] ea, input logic er, input logic et,
                                    input logic eb);
        add(1'b1, 1'b1, 16'h0000, 8'h00, h, ch, x, ea, er, et, eb);
    endfunction

    initial begin
        // Program ch1 addr=0x1234 cnt=2, with an out-of-window and a cs-high write in between.
        add_wr(1'b0, 16'd12, 8'h00);
        add_wr(1'b0, 16'h0010, 8'h55);
        add_wr(1'b1, 16'd2, 8'h99);
        add_wr(1'b0, 16'd2, 8'h34);
        add_wr(1'b0, 16'd2, 8'h12);
        add_wr(1'b0, 16'd3, 8'h02);
        add_wr(1'b0, 16'd3, 8'h00);
        add_run(1'b1, 2'd1, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1);
        add_run(1'b1, 2'd1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1);
        add_run(1'b1, 2'd1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        add_run(1'b1, 2'd1, 1'b0, 16'h1235, 1'b1, 1'b0, 1'b1);
        add_run(1'b1, 2'd1, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b1);  // xfer_done in ADDR ignored
        add_run(1'b1, 2'd1, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b1);
        add_run(1'b1, 2'd1, 1'b0, 16'h1236, 1'b1, 1'b0, 1'b1);
        add_run(1'b1, 2'd1, 1'b0, 16'h1236, 1'b0, 1'b0, 1'b1);
        add_run(1'b1, 2'd0, 1'b0, 16'h1236, 1'b0, 1'b0, 1'b1);  // chan_sel change ignored
        add_run(1'b1, 2'd1, 1'b1, 16'h1236, 1'b0, 1'b1, 1'b1);
        add_run(1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        add_run(1'b1, 2'd1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);  // ch1 masked after TC

        cs = 1'b1; IOW = 1'b1; address_bus = '0; data_bus = '0;
        HLDA = 1'b0; chan_sel = '0; xfer_done = 1'b0;
        reset = 1'b0;
        #1;
        expect_out("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].cs, vecs[i].iow, vecs[i].addr, vecs[i].data, vecs[i].hlda,
                  vecs[i].chan, vecs[i].xfer);
            expect_out($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_rdy, vecs[i].e_tc,
                       vecs[i].e_busy);
        end

        // Decrement on ch2 from 0x0001 with count 1, then re-arm to observe the wrap to 0xFFFF.
        wr(16'd12, 8'h00);
        wr(16'd11, 8'h22);
        wr(16'd4, 8'h01);
        wr(16'd4, 8'h00);
        wr(16'd5, 8'h01);
        wr(16'd5, 8'h00);
        cyc(1'b1, 2'd2, 1'b0); expect_out("dec_addr0", 16'h0001, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 2'd2, 1'b0);
        cyc(1'b1, 2'd2, 1'b1); expect_out("dec_upd0", 16'h0001, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 2'd2, 1'b0); expect_out("dec_addr1", 16'h0000, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 2'd2, 1'b0);
        cyc(1'b1, 2'd2, 1'b1); expect_out("dec_tc", 16'h0000, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 2'd2, 1'b0); expect_out("dec_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
        wr(16'd12, 8'h00);
        wr(16'd5, 8'h00);
        wr(16'd5, 8'h00);
        cyc(1'b1, 2'd2, 1'b0); expect_out("dec_wrap", 16'hFFFF, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 2'd2, 1'b0);
        cyc(1'b1, 2'd2, 1'b1); expect_out("dec_wrap_tc", 16'hFFFF, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 2'd2, 1'b0);

        // Asynchronous reset while ch1 waits for its transfer.
        wr(16'd12, 8'h00);
        wr(16'd3, 8'h05);
        wr(16'd3, 8'h00);
        cyc(1'b1, 2'd1, 1'b0); expect_out("rst_pre_addr", 16'h1237, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 2'd1, 1'b0); expect_out("rst_pre_wait", 16'h1237, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        #2;
        expect_out("rst_async", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 2'd1, 1'b0); expect_out("rst_mask1", 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0); expect_out("rst_mask1b", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Write while HLDA=1 must be ignored (regs and byte pointer untouched).
        drive(1'b0, 1'b0, 16'd0, 8'h77, 1'b1, 2'd3, 1'b0);
        expect_out("hlda_wr_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'd0, 8'h00, 1'b1, 2'd3, 1'b0);
        cyc(1'b0, 2'd0, 1'b0);
        wr(16'd1, 8'h00);
        wr(16'd1, 8'h00);
        cyc(1'b1, 2'd0, 1'b0); expect_out("hlda_wr_ignored", 16'h0000, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 2'd0, 1'b0);
        cyc(1'b1, 2'd0, 1'b1); expect_out("cnt0_tc", 16'h0000, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 2'd0, 1'b0);

        // Byte-pointer clear, then little-endian address bytes.
        wr(16'd0, 8'hEE);
        wr(16'd12, 8'h00);
        wr(16'd0, 8'hCD);
        wr(16'd0, 8'hAB);
        wr(16'd1, 8'h01);
        wr(16'd1, 8'h00);

        // HLDA drop in WAIT: back to IDLE without stepping, then resume at the same address.
        cyc(1'b1, 2'd0, 1'b0); expect_out("bp_addr", 16'hABCD, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 2'd0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0); expect_out("hlda_drop", 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 1'b0); expect_out("hlda_resume", 16'hABCD, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 2'd0, 1'b0);
        cyc(1'b1, 2'd0, 1'b1); expect_out("resume_upd", 16'hABCD, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 2'd0, 1'b0); expect_out("resume_next", 16'hABCE, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 2'd0, 1'b0);
        cyc(1'b1, 2'd0, 1'b1); expect_out("resume_tc", 16'hABCE, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 2'd0, 1'b0);

        // Autoinit on ch0: base 0x0100, count 0.
        wr(16'd11, 8'h10);
        wr(16'd12, 8'h00);
        wr(16'd0, 8'h00);
        wr(16'd0, 8'h01);
        wr(16'd1, 8'h00);
        wr(16'd1, 8'h00);
        cyc(1'b1, 2'd0, 1'b0); expect_out("ai_addr", 16'h0100, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 2'd0, 1'b0);
        cyc(1'b1, 2'd0, 1'b1); expect_out("ai_tc", 16'h0100, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 2'd0, 1'b0); expect_out("ai_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 1'b0);
`ifdef DMA_AUTOINIT_EN
        expect_out("ai_restart", 16'h0100, 1'b1, 1'b0, 1'b1);
`else
        expect_out("ai_masked", 16'h0000, 1'b0, 1'b0, 1'b0);
`endif
        cyc(1'b0, 2'd0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0);

        // Master clear: re-masks an armed channel and zeroes its current address.
        wr(16'd12, 8'h00);
        wr(16'd5, 8'h03);
        wr(16'd5, 8'h00);
        wr(16'd13, 8'h00);
        cyc(1'b1, 2'd2, 1'b0); expect_out("mclr_masked", 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 2'd2, 1'b0);
        wr(16'd5, 8'h00);
        wr(16'd5, 8'h00);
        cyc(1'b1, 2'd2, 1'b0); expect_out("mclr_addr0", 16'h0000, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 2'd2, 1'b0);
        cyc(1'b0, 2'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
